// File: rtl/full_adder_structure_pkg.sv
// full_adder_structure_pkg: shared result type for the full adder slice
package full_adder_structure_pkg;
  typedef struct packed {
    logic co;
    logic s;
  } fa_res_t;
endpackage

// File: rtl/full_adder_structure_if.sv
// full_adder_structure_if: bundles operand and result signals of one adder slice
interface full_adder_structure_if;
  logic a;
  logic b;
  logic ci;
  logic s;
  logic co;
  logic s_q;
  logic co_q;
  modport master (output a, b, ci, input s, co, s_q, co_q);
  modport slave (input a, b, ci, output s, co, s_q, co_q);
endinterface

// File: rtl/half_adder.sv
// half_adder: xor/and pair producing sum and carry of two bits
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  assign sum = x ^ y;
  assign carry = x & y;
endmodule

// File: rtl/full_adder_structure.sv
// full_adder_structure: gate-level full adder with a registered copy of its results
module full_adder_structure
  import full_adder_structure_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s,
  input  logic clk,
  input  logic rst_n,
  output logic s_q,
  output logic co_q
);
  logic w_p, w_g, w_t;
  fa_res_t r_q;
  half_adder u_ha0 (.x(a), .y(b), .sum(w_p), .carry(w_g));
  half_adder u_ha1 (.x(w_p), .y(ci), .sum(s), .carry(w_t));
  assign co = w_g | w_t;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= '{co: co, s: s};
  assign s_q = r_q.s;
  assign co_q = r_q.co;
endmodule

// File: tb/tb_full_adder_structure.sv
// tb_full_adder_structure: directed checks of the combinational and registered adder outputs
module tb_full_adder_structure;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] s_tab = 8'b1001_0110;
  logic [7:0] co_tab = 8'b1110_1000;
  logic [2:0] v;
  full_adder_structure_if ifc ();
  full_adder_structure dut (
    .a(ifc.a), .b(ifc.b), .ci(ifc.ci), .co(ifc.co), .s(ifc.s),
    .clk(clk), .rst_n(rst_n), .s_q(ifc.s_q), .co_q(ifc.co_q)
  );
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask
  task automatic drive(input logic [2:0] abc);
    {ifc.a, ifc.b, ifc.ci} = abc;
    #1;
  endtask
  initial begin
    drive(3'b000);
    chk("reset_q", {ifc.co_q, ifc.s_q}, 2'b00);
    tick;
    chk("reset_hold_q", {ifc.co_q, ifc.s_q}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("zero_comb", {ifc.co, ifc.s}, 2'b00);
    tick;
    chk("zero_q", {ifc.co_q, ifc.s_q}, 2'b00);
    drive(3'b110);
    chk("generate", {ifc.co, ifc.s}, 2'b10);
    drive(3'b101);
    chk("propagate_ci", {ifc.co, ifc.s}, 2'b10);
    drive(3'b001);
    chk("ci_only", {ifc.co, ifc.s}, 2'b01);
    drive(3'b111);
    chk("max_comb", {ifc.co, ifc.s}, 2'b11);
    chk("max_q_before_edge", {ifc.co_q, ifc.s_q}, 2'b00);
    tick;
    chk("max_q", {ifc.co_q, ifc.s_q}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {ifc.a, ifc.b, ifc.ci} = v;
      #40;
      chk($sformatf("sweep_tab_%0d", i), {ifc.co, ifc.s}, {co_tab[i], s_tab[i]});
      chk($sformatf("sweep_sum_%0d", i), {ifc.co, ifc.s}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
    end
    drive(3'b010);
    tick;
    chk("q_follows_010", {ifc.co_q, ifc.s_q}, 2'b01);
    drive(3'b111);
    tick;
    chk("rst_pre_q", {ifc.co_q, ifc.s_q}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_q", {ifc.co_q, ifc.s_q}, 2'b00);
    chk("rst_comb", {ifc.co, ifc.s}, 2'b11);
    tick;
    chk("rst_held_q", {ifc.co_q, ifc.s_q}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("rst_release_no_edge", {ifc.co_q, ifc.s_q}, 2'b00);
    tick;
    chk("rst_release_q", {ifc.co_q, ifc.s_q}, 2'b11);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
